mem_stage_access: RTL and testbench

- MEM-stage data-memory access controller for the pipelined LC-3b.
- Consumes the instruction held in the EX/MEM pipeline register (opcode, ALU-computed address, store data).
- Runs the data-memory read/write handshake, including two-access LDI/STI sequences, and stalls the pipeline until the access completes.
- Presents sign-extended/aligned load data to the MEM/WB register.

---
 rtl/mem_stage_access.sv | 186 ++++++++++++++++++
 tb/tb_mem_stage_access.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access.sv
// MEM-stage data-memory access controller for the pipelined LC-3b.
// Takes the instruction sitting in EX/MEM and runs the data-memory
// handshake for LDB/LDW/LDI/STB/STW/STI, including the two-access indirect
// forms. It holds the pipeline until the access completes, then presents
// the formatted load result to MEM/WB.
// Request outputs are decoded from registered state only, so they are
// glitch-free with respect to the pipeline inputs and stay stable while
// the memory is waiting.
module mem_stage_access (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid,
    input  logic [3:0]  opcode,
    input  logic [15:0] addr,
    input  logic [15:0] store_data,
    input  logic        advance,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_byte_enable,
    output logic        stall,
    output logic [15:0] load_data
);

    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_LDW = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STB = 4'b0011;
    localparam logic [3:0] OP_STW = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD1,
        S_RD2,
        S_WR,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q,    op_d;
    logic [15:0] addr_q,  addr_d;
    logic [15:0] sdata_q, sdata_d;
    logic [15:0] ptr_q,   ptr_d;
    logic [15:0] load_q,  load_d;

    // True for every opcode that touches data memory.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDB) || (op == OP_LDW) || (op == OP_LDI) ||
               (op == OP_STB) || (op == OP_STW) || (op == OP_STI);
    endfunction

    // Stores that write directly, without first fetching a pointer.
    function automatic logic is_direct_store(input logic [3:0] op);
        return (op == OP_STB) || (op == OP_STW);
    endfunction

    // The memory is word-addressed on the bus; drop the byte-select bit.
    function automatic logic [15:0] word_align(input logic [15:0] a);
        return {a[15:1], 1'b0};
    endfunction

    // Load formatting: LDB picks the addressed byte and sign-extends it,
    // LDW passes the word through unchanged.
    function automatic logic [15:0] format_load(input logic [3:0]  op,
                                                input logic        lsb,
                                                input logic [15:0] rdata);
        logic signed [7:0]  byte_s;
        logic signed [15:0] ext_s;
        byte_s = lsb ? rdata[15:8] : rdata[7:0];
        ext_s  = 16'(byte_s);
        return (op == OP_LDB) ? ext_s : rdata;
    endfunction

    // Next-state, latch updates and request/stall outputs.
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        addr_d          = addr_q;
        sdata_d         = sdata_q;
        ptr_d           = ptr_q;
        load_d          = load_q;
        stall           = 1'b1;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = 16'h0000;
        mem_wdata       = 16'h0000;
        mem_byte_enable = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (valid && is_mem_op(opcode)) begin
                    // Capture the instruction so upstream may change freely.
                    op_d    = opcode;
                    addr_d  = addr;
                    sdata_d = store_data;
                    state_d = is_direct_store(opcode) ? S_WR : S_RD1;
                end else begin
                    stall = 1'b0;
                end
            end

            S_RD1: begin
                mem_read    = 1'b1;
                mem_address = word_align(addr_q);
                if (mem_resp) begin
                    case (op_q)
                        OP_LDI: begin
                            ptr_d   = mem_rdata;
                            state_d = S_RD2;
                        end
                        OP_STI: begin
                            ptr_d   = mem_rdata;
                            state_d = S_WR;
                        end
                        default: begin
                            load_d  = format_load(op_q, addr_q[0], mem_rdata);
                            state_d = S_DONE;
                        end
                    endcase
                end
            end

            S_RD2: begin
                mem_read    = 1'b1;
                mem_address = word_align(ptr_q);
                if (mem_resp) begin
                    load_d  = mem_rdata;
                    state_d = S_DONE;
                end
            end

            S_WR: begin
                mem_write   = 1'b1;
                mem_address = (op_q == OP_STI) ? word_align(ptr_q) : word_align(addr_q);
                if (op_q == OP_STB) begin
                    // Replicate the byte on both lanes; the enable picks one.
                    mem_wdata       = {sdata_q[7:0], sdata_q[7:0]};
                    mem_byte_enable = addr_q[0] ? 2'b10 : 2'b01;
                end else begin
                    mem_wdata       = sdata_q;
                    mem_byte_enable = 2'b11;
                end
                if (mem_resp) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                stall = 1'b0;
                if (advance) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and instruction latches; reset abandons any in-flight request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= 4'h0;
            addr_q  <= 16'h0000;
            sdata_q <= 16'h0000;
            ptr_q   <= 16'h0000;
            load_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            ptr_q   <= ptr_d;
            load_q  <= load_d;
        end
    end

    assign load_data = load_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// Self-checking bench for mem_stage_access: a driver issues instructions and
// queues the expected memory requests and results from a word-array model;
// a monitor plays the data memory, and checks every request and completion.
module tb_mem_stage_access;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid;
    logic [3:0]  opcode;
    logic [15:0] addr;
    logic [15:0] store_data;
    logic        advance;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic        stall;
    logic [15:0] load_data;

    mem_stage_access dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .valid           (valid),
        .opcode          (opcode),
        .addr            (addr),
        .store_data      (store_data),
        .advance         (advance),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .stall           (stall),
        .load_data       (load_data)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] LDB = 4'h2, LDW = 4'h6, LDI = 4'hA;
    localparam logic [3:0] STB = 4'h3, STW = 4'h7, STI = 4'hB;

    typedef struct packed {
        logic        wr;
        logic [15:0] a;
        logic [15:0] wd;
        logic [1:0]  be;
    } req_t;

    typedef struct packed {
        logic [7:0]  nreq;
        logic [15:0] ld;
    } done_t;

    req_t        exp_req[$];
    done_t       exp_done[$];
    logic [15:0] ref_mem [0:32767];
    logic [15:0] dut_mem [0:32767];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          forced_wait = -1;
    bit          no_resp = 1'b0;
    bit          mon_en  = 1'b0;
    bit          in_req  = 1'b0;
    bit          prev_stall = 1'b0;
    int          wait_left, wait_plan, waits_sum, cyc, detect_cyc;
    logic [15:0] exp_load_cur = 16'h0000;
    logic [15:0] model_load   = 16'h0000;
    req_t        snap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    function automatic bit is_mem(input logic [3:0] op);
        return (op == LDB) || (op == LDW) || (op == LDI) ||
               (op == STB) || (op == STW) || (op == STI);
    endfunction

    function automatic req_t mk_req(input logic wr, input logic [15:0] a,
                                    input logic [15:0] wd, input logic [1:0] be);
        req_t r;
        r.wr = wr;
        r.a  = {a[15:1], 1'b0};
        r.wd = wd;
        r.be = be;
        return r;
    endfunction

    task automatic poke(input logic [15:0] a, input logic [15:0] v);
        ref_mem[a[15:1]] = v;
        dut_mem[a[15:1]] = v;
    endtask

    task automatic scramble();
        valid      = 1'($urandom);
        opcode     = 4'($urandom);
        addr       = 16'($urandom);
        store_data = 16'($urandom);
    endtask

    // Data memory plus output checker, active on the falling edge.
    task automatic monitor_step();
        done_t d;
        req_t  r;
        bit    req;
        logic [15:0] w;
        cyc++;
        req = (mem_read === 1'b1) || (mem_write === 1'b1);
        check("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'd0);

        if (stall === 1'b1 && !prev_stall) begin
            detect_cyc = cyc;
            waits_sum  = 0;
        end
        if (stall === 1'b0 && prev_stall) begin
            if (exp_done.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL spurious_done: got completion, expected none (t=%0t)", $time);
            end else begin
                d = exp_done.pop_front();
                check("latency", cyc - detect_cyc, 32'(d.nreq) + 1 + waits_sum);
                check("requests_left", exp_req.size(), 32'd0);
                exp_load_cur = d.ld;
            end
        end
        prev_stall = (stall === 1'b1);
        if (stall === 1'b0) check("load_data", load_data, exp_load_cur);

        if (req) begin
            check("stall_busy", stall, 32'd1);
            if (!in_req) begin
                if (exp_req.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_req: got rd=%b wr=%b addr=%h, expected no request",
                             mem_read, mem_write, mem_address);
                end else begin
                    r = exp_req.pop_front();
                    check("req_is_write", mem_write, r.wr);
                    check("req_is_read", mem_read, !r.wr);
                    check("req_addr", mem_address, r.a);
                    if (r.wr) begin
                        check("req_wdata", mem_wdata, r.wd);
                        check("req_byte_en", mem_byte_enable, r.be);
                    end
                end
                in_req  = 1'b1;
                snap.wr = mem_write;
                snap.a  = mem_address;
                snap.wd = mem_wdata;
                snap.be = mem_byte_enable;
                wait_plan = no_resp ? 1000000 :
                            (forced_wait >= 0 ? forced_wait : int'($urandom_range(0, 3)));
                wait_left = wait_plan;
                waits_sum += wait_plan;
            end else begin
                check("hold_addr", mem_address, snap.a);
                check("hold_write", mem_write, snap.wr);
                check("hold_wdata", mem_wdata, snap.wd);
                check("hold_byte_en", mem_byte_enable, snap.be);
            end
            if (wait_left == 0) begin
                mem_resp = 1'b1;
                if (mem_read === 1'b1) begin
                    mem_rdata = dut_mem[mem_address[15:1]];
                end else begin
                    w = dut_mem[mem_address[15:1]];
                    if (mem_byte_enable[1]) w[15:8] = mem_wdata[15:8];
                    if (mem_byte_enable[0]) w[7:0]  = mem_wdata[7:0];
                    dut_mem[mem_address[15:1]] = w;
                    mem_rdata = 16'($urandom);
                end
                in_req = 1'b0;
            end else begin
                mem_resp  = 1'b0;
                mem_rdata = 16'($urandom);
                wait_left--;
            end
        end else begin
            check("req_dropped", {31'b0, in_req}, 32'd0);
            in_req    = 1'b0;
            mem_resp  = ($urandom_range(0, 2) == 0);
            mem_rdata = 16'($urandom);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) monitor_step();
        end
    end

    // Present one memory instruction, queue expectations, wait for DONE.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] sd);
        done_t       d;
        logic [15:0] w, p;
        logic [7:0]  b;
        int          cnt;
        w = ref_mem[a[15:1]];
        d.nreq = 8'd1;
        case (op)
            LDW: begin
                exp_req.push_back(mk_req(1'b0, a, 16'h0, 2'b00));
                model_load = w;
            end
            LDB: begin
                exp_req.push_back(mk_req(1'b0, a, 16'h0, 2'b00));
                b = a[0] ? w[15:8] : w[7:0];
                model_load = (b >= 8'h80) ? (16'hFF00 + 16'(b)) : 16'(b);
            end
            LDI: begin
                p = w;
                exp_req.push_back(mk_req(1'b0, a, 16'h0, 2'b00));
                exp_req.push_back(mk_req(1'b0, p, 16'h0, 2'b00));
                model_load = ref_mem[p[15:1]];
                d.nreq = 8'd2;
            end
            STW: begin
                exp_req.push_back(mk_req(1'b1, a, sd, 2'b11));
                ref_mem[a[15:1]] = sd;
            end
            STB: begin
                exp_req.push_back(mk_req(1'b1, a, {sd[7:0], sd[7:0]}, a[0] ? 2'b10 : 2'b01));
                if (a[0]) ref_mem[a[15:1]][15:8] = sd[7:0];
                else      ref_mem[a[15:1]][7:0]  = sd[7:0];
            end
            default: begin // STI
                p = w;
                exp_req.push_back(mk_req(1'b0, a, 16'h0, 2'b00));
                exp_req.push_back(mk_req(1'b1, p, sd, 2'b11));
                ref_mem[p[15:1]] = sd;
                d.nreq = 8'd2;
            end
        endcase
        d.ld = model_load;
        exp_done.push_back(d);

        valid = 1'b1; opcode = op; addr = a; store_data = sd; advance = 1'b0;
        @(negedge clk);
        check("stall_detect", stall, 32'd1);
        @(posedge clk); #1;
        scramble();
        cnt = 0;
        @(negedge clk);
        while (stall !== 1'b0 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("done_reached", stall, 32'd0);
        if (stall !== 1'b0) finish_run();
    endtask

    // Stay in DONE for 'hold' extra cycles, then let the pipeline advance.
    task automatic finish_done(input int hold);
        repeat (hold) begin
            @(posedge clk); #1;
            scramble();
            advance = 1'b0;
        end
        advance = 1'b1;
        valid   = 1'b0;
        @(posedge clk); #1;
        advance = 1'b0;
    endtask

    task automatic idle_op(input logic [3:0] op, input logic v);
        valid = v; opcode = op; addr = 16'($urandom); store_data = 16'($urandom);
        @(negedge clk);
        check("stall_no_memop", stall, 32'd0);
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    logic [3:0]  memops [6] = '{LDB, LDW, LDI, STB, STW, STI};
    logic [15:0] tmp;

    initial begin
        #500000;
        n_tests++; n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_run();
    end

    initial begin
        int diffs;
        logic [3:0]  op;
        logic [15:0] a;
        for (int i = 0; i < 32768; i++) begin
            tmp = 16'($urandom);
            ref_mem[i] = tmp;
            dut_mem[i] = tmp;
        end
        reset_n = 1'b0; valid = 1'b0; opcode = 4'h0; addr = 16'h0;
        store_data = 16'h0; advance = 1'b0; mem_resp = 1'b0; mem_rdata = 16'h0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("reset_stall", stall, 32'd0);
        check("reset_read", mem_read, 32'd0);
        check("reset_write", mem_write, 32'd0);
        check("reset_addr", mem_address, 32'd0);
        check("reset_load", load_data, 32'd0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Directed cases with known values.
        forced_wait = 3;
        poke(16'h1234, 16'hBEEF);
        issue(LDW, 16'h1235, 16'h0000);
        check("ldw_beef", load_data, 32'hBEEF);
        finish_done(0);

        forced_wait = 0;
        poke(16'h2000, 16'h80FF);
        issue(LDB, 16'h2001, 16'h0000);
        check("ldb_high", load_data, 32'hFF80);
        finish_done(1);
        issue(LDB, 16'h2000, 16'h0000);
        check("ldb_low", load_data, 32'hFFFF);
        finish_done(0);

        issue(STB, 16'h4003, 16'h12AB);
        tmp = dut_mem[15'h2001];
        check("stb_high_lane", tmp[15:8], 32'hAB);
        finish_done(0);

        poke(16'h0100, 16'h0A01);
        poke(16'h0A00, 16'h5555);
        issue(LDI, 16'h0100, 16'h0000);
        check("ldi_value", load_data, 32'h5555);
        finish_done(0);

        issue(STI, 16'h0100, 16'h7777);
        check("sti_word", dut_mem[15'h0500], 32'h7777);
        check("store_keeps_load", load_data, 32'h5555);
        finish_done(5);

        idle_op(4'b0001, 1'b1);
        idle_op(LDW, 1'b0);

        // Reset while a read is outstanding and the memory never answers.
        no_resp = 1'b1;
        poke(16'h3000, 16'h1111);
        exp_req.push_back(mk_req(1'b0, 16'h3000, 16'h0, 2'b00));
        exp_done.push_back('{nreq: 8'd1, ld: 16'h1111});
        valid = 1'b1; opcode = LDW; addr = 16'h3000; advance = 1'b0;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_read", mem_read, 32'd1);
        @(posedge clk); #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async_rst_read", mem_read, 32'd0);
        check("async_rst_addr", mem_address, 32'd0);
        check("async_rst_stall", stall, 32'd0);
        check("async_rst_load", load_data, 32'd0);
        check("async_rst_be", mem_byte_enable, 32'd0);
        @(negedge clk);
        @(posedge clk); #2;
        reset_n = 1'b1;
        no_resp = 1'b0; forced_wait = -1; in_req = 1'b0; prev_stall = 1'b0;
        mem_resp = 1'b0; exp_load_cur = 16'h0; model_load = 16'h0;
        exp_req.delete(); exp_done.delete();
        @(negedge clk);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic with random memory wait states.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                op = memops[$urandom_range(0, 5)];
                a  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 63)) : 16'($urandom);
                issue(op, a, 16'($urandom));
                finish_done(int'($urandom_range(0, 3)));
            end else if ($urandom_range(0, 1) == 1) begin
                do op = 4'($urandom); while (is_mem(op));
                idle_op(op, 1'b1);
            end else begin
                idle_op(4'($urandom), 1'b0);
            end
        end

        repeat (2) @(negedge clk);
        diffs = 0;
        for (int i = 0; i < 32768; i++) begin
            if (ref_mem[i] !== dut_mem[i]) diffs++;
        end
        check("memory_image", diffs, 32'd0);
        finish_run();
    end

endmodule
